// File: rtl/tpu_seq.sv
// Sequencer that loads a 3x3 systolic array: weights, skewed data, drain, then captures the accumulators.
// Optional run counter output perf_runs is enabled with `define TPU_SEQ_PERF_EN.
module tpu_seq #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [1:0]  wr_row,
  input  logic [23:0] wr_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [71:0] result,
  output logic        mmu_reset,
  output logic        mmu_control,
  output logic [23:0] mmu_wt_arr,
  output logic [23:0] mmu_data_arr,
  input  logic [71:0] mmu_acc_out
`ifdef TPU_SEQ_PERF_EN
  ,
  output logic [15:0] perf_runs
`endif
);

  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_WLOAD = 3'd2;
  localparam logic [2:0] S_FEED  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_CAPT  = 3'd5;

  logic [2:0]    r_state;
  logic [2:0]    r_step;
  logic [DW-1:0] r_drain_cnt;
  logic [23:0]   r_wt_buf   [0:2];
  logic [23:0]   r_data_buf [0:2];
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [71:0]   r_result;
  logic          r_mmu_reset;
  logic          r_mmu_control;
  logic [23:0]   r_mmu_wt_arr;
  logic [23:0]   r_mmu_data_arr;

  logic [2:0]    w_state_nxt;
  logic [2:0]    w_step_nxt;
  logic [DW-1:0] w_drain_nxt;
  logic [23:0]   w_wt_nxt;
  logic [23:0]   w_data_nxt;
  logic          w_wr_ok;
  logic          w_reject;

  assign w_wr_ok  = wr_en && (r_state == S_IDLE) && (wr_row != 2'd3);
  assign w_reject = (wr_en || start) && (r_state != S_IDLE);

  // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_drain_nxt = r_drain_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CLR;
          w_step_nxt  = 3'd0;
          w_drain_nxt = '0;
        end
      end
      S_CLR: begin
        w_state_nxt = S_WLOAD;
        w_step_nxt  = 3'd0;
      end
      S_WLOAD: begin
        if (r_step == 3'd2) begin
          w_state_nxt = S_FEED;
          w_step_nxt  = 3'd0;
        end else begin
          w_step_nxt = r_step + 3'd1;
        end
      end
      S_FEED: begin
        if (r_step == 3'd4) begin
          w_state_nxt = (DRAIN_CYCLES == 0) ? S_CAPT : S_DRAIN;
          w_step_nxt  = 3'd0;
          w_drain_nxt = '0;
        end else begin
          w_step_nxt = r_step + 3'd1;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) begin
          w_state_nxt = S_CAPT;
          w_drain_nxt = '0;
        end else begin
          w_drain_nxt = r_drain_cnt + 1'b1;
        end
      end
      S_CAPT:  w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt = S_IDLE;
        w_step_nxt  = 3'd0;
        w_drain_nxt = '0;
      end
    endcase
  end

  // Bus values are computed for the state about to be entered so the outputs can be registered.
  always_comb begin
    w_wt_nxt   = '0;
    w_data_nxt = '0;
    if (w_state_nxt == S_WLOAD) begin
      case (w_step_nxt)
        3'd0:    w_wt_nxt = r_wt_buf[0];
        3'd1:    w_wt_nxt = r_wt_buf[1];
        3'd2:    w_wt_nxt = r_wt_buf[2];
        default: w_wt_nxt = '0;
      endcase
    end
    if (w_state_nxt == S_FEED) begin
      // Diagonal skew: lane k carries row (t-k).
      case (w_step_nxt)
        3'd0: w_data_nxt = {8'h00, 8'h00, r_data_buf[0][7:0]};
        3'd1: w_data_nxt = {8'h00, r_data_buf[0][15:8], r_data_buf[1][7:0]};
        3'd2: w_data_nxt = {r_data_buf[0][23:16], r_data_buf[1][15:8], r_data_buf[2][7:0]};
        3'd3: w_data_nxt = {r_data_buf[1][23:16], r_data_buf[2][15:8], 8'h00};
        3'd4: w_data_nxt = {r_data_buf[2][23:16], 8'h00, 8'h00};
        default: w_data_nxt = '0;
      endcase
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  // NOTE: the row buffers are cleared by reset, so they live in the reset branch rather than as a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_step         <= 3'd0;
      r_drain_cnt    <= '0;
      for (int i = 0; i < 3; i++) begin
        r_wt_buf[i]   <= '0;
        r_data_buf[i] <= '0;
      end
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_result       <= '0;
      r_mmu_reset    <= 1'b1;
      r_mmu_control  <= 1'b0;
      r_mmu_wt_arr   <= '0;
      r_mmu_data_arr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_step      <= w_step_nxt;
      r_drain_cnt <= w_drain_nxt;
      if (w_wr_ok) begin
        if (wr_sel) r_data_buf[wr_row] <= wr_data;
        else        r_wt_buf[wr_row]   <= wr_data;
      end
      r_busy         <= (w_state_nxt != S_IDLE);
      r_done         <= (r_state == S_CAPT);
      r_err          <= w_reject;
      if (r_state == S_CAPT) r_result <= mmu_acc_out;
      r_mmu_reset    <= (w_state_nxt == S_CLR);
      r_mmu_control  <= (w_state_nxt == S_WLOAD) || (w_state_nxt == S_FEED);
      r_mmu_wt_arr   <= w_wt_nxt;
      r_mmu_data_arr <= w_data_nxt;
    end
  end

`ifdef TPU_SEQ_PERF_EN
  logic [15:0] r_perf_runs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_perf_runs <= '0;
    else if (r_state == S_CAPT) r_perf_runs <= r_perf_runs + 16'd1;
  end

  assign perf_runs = r_perf_runs;
`endif

  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign result       = r_result;
  assign mmu_reset    = r_mmu_reset;
  assign mmu_control  = r_mmu_control;
  assign mmu_wt_arr   = r_mmu_wt_arr;
  assign mmu_data_arr = r_mmu_data_arr;

endmodule
